// File: rtl/demux_serial_feeder_if.sv
// Upstream handshake bundle for the demux serial feeder: a {channel, data}
// word offered on a valid/ready pair.
interface demux_serial_feeder_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_chan;
    logic [DATA_W-1:0] in_data;

    // Producer side: offers words and watches ready
    modport master (
        output in_valid,
        output in_chan,
        output in_data,
        input  in_ready
    );

    // Feeder side: consumes words and reports ready
    modport slave (
        input  in_valid,
        input  in_chan,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/demux_serial_feeder.sv
// Demux serial feeder: buffers one {channel, word} transfer and shifts the
// word out one bit per cycle on din while sel addresses the target demux
// output. A programmable run of idle cycles (din=0) separates words, and a
// held word may be loaded straight behind the current one when no gap is
// configured.
module demux_serial_feeder #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_serial_feeder_if.slave  bus,
    input  logic                  abort,
    output logic                  din,
    output logic [2:0]            sel,
    output logic                  bit_valid,
    output logic                  last_bit,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BIT_LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               hold_full, hold_full_nxt;
    logic [2:0]         hold_chan, hold_chan_nxt;
    logic [DATA_W-1:0]  hold_data, hold_data_nxt;
    logic [DATA_W-1:0]  shreg, shreg_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [3:0]         gap_cnt, gap_cnt_nxt;
    logic               din_nxt;
    logic [2:0]         sel_nxt;
    logic               bit_valid_nxt;
    logic               last_bit_nxt;
    logic               load_word;
    logic               accept;
    logic               in_ready_int;

    // The bit that leaves the word first in the configured shift order
    function automatic logic out_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    // The word with its leading bit consumed, so the next bit moves into place
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // Ready only reflects buffer space; it is held low while reset is active
    assign in_ready_int = !hold_full && rst_n;
    assign bus.in_ready = in_ready_int;
    assign accept       = bus.in_valid && in_ready_int;
    assign busy         = (state != IDLE) || hold_full;

    // Next-state and next-output decode; abort overrides load and shift
    always_comb begin
        state_nxt     = state;
        hold_full_nxt = hold_full;
        hold_chan_nxt = hold_chan;
        hold_data_nxt = hold_data;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        gap_cnt_nxt   = gap_cnt;
        din_nxt       = 1'b0;
        sel_nxt       = sel;
        bit_valid_nxt = 1'b0;
        last_bit_nxt  = 1'b0;
        load_word     = 1'b0;

        if (abort) begin
            state_nxt     = IDLE;
            hold_full_nxt = 1'b0;
        end else begin
            if (accept) begin
                hold_full_nxt = 1'b1;
                hold_chan_nxt = bus.in_chan;
                hold_data_nxt = bus.in_data;
            end

            case (state)
                IDLE: begin
                    load_word = hold_full;
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        din_nxt       = out_bit(shreg);
                        shreg_nxt     = advance(shreg);
                        bit_valid_nxt = 1'b1;
                        bit_cnt_nxt   = bit_cnt - CNT_W'(1);
                        last_bit_nxt  = (bit_cnt == CNT_W'(1));
                    end else if (GAP_CYCLES > 0) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end else if (hold_full) begin
                        load_word = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt_nxt = gap_cnt - 4'd1;
                    end else if (hold_full) begin
                        load_word = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (load_word) begin
                state_nxt     = SHIFT;
                shreg_nxt     = advance(hold_data);
                din_nxt       = out_bit(hold_data);
                sel_nxt       = hold_chan;
                bit_valid_nxt = 1'b1;
                last_bit_nxt  = 1'b0;
                bit_cnt_nxt   = BIT_LAST_IDX;
                hold_full_nxt = 1'b0;
            end
        end
    end

    // State, buffer and registered outputs; reset drops everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            hold_chan <= 3'd0;
            hold_data <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= 4'd0;
            din       <= 1'b0;
            sel       <= 3'd0;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_full <= hold_full_nxt;
            hold_chan <= hold_chan_nxt;
            hold_data <= hold_data_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            din       <= din_nxt;
            sel       <= sel_nxt;
            bit_valid <= bit_valid_nxt;
            last_bit  <= last_bit_nxt;
        end
    end

endmodule

// File: tb/tb_demux_serial_feeder.sv
// Bench for the demux serial feeder. Instance A (8 bits, one gap cycle,
// MSB first) is watched by a word-level reference model that tracks accepted
// words in a queue and predicts bits, readiness and start timing. Instance B
// (no gap, LSB first) covers back-to-back loading and bit order directly.
module tb_demux_serial_feeder;

    localparam int GAP_A = 1;

    logic clk;
    logic rst_n;

    logic       abortA, dinA, bvA, lastA, busyA;
    logic [2:0] selA;
    logic       abortB, dinB, bvB, lastB, busyB;
    logic [2:0] selB;

    demux_serial_feeder_if #(.DATA_W(8)) ifa ();
    demux_serial_feeder_if #(.DATA_W(8)) ifb ();

    demux_serial_feeder #(.DATA_W(8), .GAP_CYCLES(GAP_A), .MSB_FIRST(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifa),
        .abort     (abortA),
        .din       (dinA),
        .sel       (selA),
        .bit_valid (bvA),
        .last_bit  (lastA),
        .busy      (busyA)
    );

    demux_serial_feeder #(.DATA_W(8), .GAP_CYCLES(0), .MSB_FIRST(0)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifb),
        .abort     (abortB),
        .din       (dinB),
        .sel       (selB),
        .bit_valid (bvB),
        .last_bit  (lastB),
        .busy      (busyB)
    );

    int compared   = 0;
    int mismatched = 0;

    // Words accepted by instance A and not yet fully observed on din
    logic [2:0] qChan[$];
    logic [7:0] qData[$];
    int idx     = 0;
    int gapLeft = 0;
    int startIn = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [7:0] d, input logic ab);
        @(posedge clk);
        #1;
        ifa.in_valid = v;
        ifa.in_chan  = c;
        ifa.in_data  = d;
        abortA       = ab;
    endtask

    // Offer a word to A and keep it up until it is taken; returns just after the accepting edge
    task automatic sendWordA(input logic [2:0] c, input logic [7:0] d, input string tag);
        bit done = 1'b0;
        applyStimulus(1'b1, c, d, 1'b0);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (ifa.in_ready) done = 1'b1;
            applyStimulus(!done, c, d, 1'b0);
        end
        if (!done) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    // Wait for A's next word and check all eight bits plus the following gap cycle
    task automatic checkWordA(input logic [2:0] c, input logic [7:0] d, input string tag);
        int waitCnt = 0;
        logic [7:0] w = d;
        @(negedge clk);
        while (!bvA && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({tag, "_start"}, bvA, 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput({tag, "_bv"}, bvA, 1);
            checkOutput({tag, "_sel"}, selA, c);
            checkOutput({tag, "_din"}, dinA, w[7-i]);
            checkOutput({tag, "_last"}, lastA, (i == 7));
            @(negedge clk);
        end
        checkOutput({tag, "_gap_bv"}, bvA, 0);
        checkOutput({tag, "_gap_din"}, dinA, 0);
    endtask

    task automatic waitDrainA(input string tag);
        int n = 0;
        while ((busyA || qData.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drain_busy"}, busyA, 0);
        checkOutput({tag, "_drain_q"}, qData.size(), 0);
    endtask

    // Word-level reference for instance A, evaluated between clock edges
    always @(negedge clk) begin : monitorA
        logic       expReady;
        logic [7:0] w;
        if (!rst_n) begin
            qChan.delete();
            qData.delete();
            idx     = 0;
            gapLeft = 0;
            startIn = 0;
        end else begin
            if (startIn > 0) begin
                checkOutput("mon_start", bvA, (startIn == 1));
                startIn--;
            end
            if (gapLeft > 0) begin
                checkOutput("mon_gap", bvA, 0);
                gapLeft--;
            end
            if (bvA) begin
                if (qData.size() == 0) begin
                    checkOutput("mon_spurious", bvA, 0);
                end else begin
                    w = qData[0];
                    checkOutput("mon_sel", selA, qChan[0]);
                    checkOutput("mon_din", dinA, w[7-idx]);
                    checkOutput("mon_last", lastA, (idx == 7));
                    idx++;
                    if (idx == 8) begin
                        void'(qChan.pop_front());
                        void'(qData.pop_front());
                        idx     = 0;
                        gapLeft = GAP_A;
                        if (qData.size() > 0) startIn = GAP_A + 1;
                    end
                end
            end else begin
                checkOutput("mon_idle", {dinA, lastA}, 0);
                if (idx != 0) begin
                    checkOutput("mon_cut", idx, 0);
                    void'(qChan.pop_front());
                    void'(qData.pop_front());
                    idx = 0;
                end
            end
            expReady = ((qData.size() - ((idx > 0) ? 1 : 0)) == 0);
            checkOutput("mon_ready", ifa.in_ready, expReady);
            if (abortA) begin
                qChan.delete();
                qData.delete();
                idx     = 0;
                gapLeft = 0;
                startIn = 0;
            end else if (ifa.in_valid && expReady) begin
                if (qData.size() == 0) startIn = (gapLeft + 1 > 2) ? gapLeft + 1 : 2;
                qChan.push_back(ifa.in_chan);
                qData.push_back(ifa.in_data);
            end
        end
    end

    // Backstop so a stuck run still ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, then randomized traffic, then the no-gap LSB-first instance
    initial begin
        logic [7:0] w;
        int n;
        bit seen;

        rst_n = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_chan = 3'd0; ifa.in_data = 8'd0; abortA = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_chan = 3'd0; ifb.in_data = 8'd0; abortB = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_din", dinA, 0);
        checkOutput("rst_sel", selA, 0);
        checkOutput("rst_bv", bvA, 0);
        checkOutput("rst_last", lastA, 0);
        checkOutput("rst_busy", busyA, 0);
        checkOutput("rst_ready_a", ifa.in_ready, 0);
        checkOutput("rst_ready_b", ifb.in_ready, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_ready", ifa.in_ready, 1);

        // Single word, MSB first, followed by one idle cycle
        sendWordA(3'd5, 8'hA5, "a5");
        checkWordA(3'd5, 8'hA5, "a5");

        // Abort on the fourth bit while a second word waits in the buffer
        sendWordA(3'd3, 8'hF0, "ab1");
        sendWordA(3'd6, 8'h3C, "ab2");
        @(negedge clk);
        checkOutput("ab_held_ready", ifa.in_ready, 0);
        checkOutput("ab_bit2_bv", bvA, 1);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
        applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
        @(negedge clk);
        checkOutput("ab_bv", bvA, 0);
        checkOutput("ab_din", dinA, 0);
        checkOutput("ab_last", lastA, 0);
        checkOutput("ab_ready", ifa.in_ready, 1);
        checkOutput("ab_busy", busyA, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvA) seen = 1'b1;
        end
        checkOutput("ab_no_emit", seen, 0);

        // Data wiggles while the buffer is full must not be captured
        sendWordA(3'd2, 8'h11, "hold1");
        sendWordA(3'd3, 8'h22, "hold2");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 3'd4, 8'($urandom), 1'b0);
            @(negedge clk);
            checkOutput("hold_ready_lo", ifa.in_ready, 0);
        end
        sendWordA(3'd4, 8'h6B, "hold3");
        waitDrainA("hold");

        // Asynchronous reset in the middle of a word
        sendWordA(3'd1, 8'hC3, "rst");
        n = 0;
        @(negedge clk);
        while (!bvA && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_mid_start", bvA, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_din", dinA, 0);
        checkOutput("rst_mid_bv", bvA, 0);
        checkOutput("rst_mid_last", lastA, 0);
        checkOutput("rst_mid_sel", selA, 0);
        checkOutput("rst_mid_ready", ifa.in_ready, 0);
        checkOutput("rst_mid_busy", busyA, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 checkOutput("rst_mid_rel_ready", ifa.in_ready, 1);
        sendWordA(3'd4, 8'h5A, "post");
        checkWordA(3'd4, 8'h5A, "post");

        // Randomized traffic with occasional aborts
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 99) < 60), 3'($urandom), 8'($urandom),
                          ($urandom_range(0, 39) == 0));
        end
        applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
        waitDrainA("rand");

        // Instance B: back-to-back words with no gap, LSB first
        @(posedge clk);
        #1 ifb.in_valid = 1'b1; ifb.in_chan = 3'd2; ifb.in_data = 8'hFF;
        @(negedge clk);
        checkOutput("b2b_rdy_first", ifb.in_ready, 1);
        @(posedge clk);
        #1 ifb.in_chan = 3'd7; ifb.in_data = 8'h01;
        @(negedge clk);
        checkOutput("b2b_rdy_held", ifb.in_ready, 0);
        checkOutput("b2b_pre_bv", bvB, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("b2b_rdy_after_load", ifb.in_ready, 1);
        for (int i = 0; i < 16; i++) begin
            w = (i < 8) ? 8'hFF : 8'h01;
            checkOutput("b2b_bv", bvB, 1);
            checkOutput("b2b_sel", selB, (i < 8) ? 3'd2 : 3'd7);
            checkOutput("b2b_din", dinB, w[i%8]);
            checkOutput("b2b_last", lastB, ((i % 8) == 7));
            @(posedge clk);
            #1;
            if (i == 0) ifb.in_valid = 1'b0;
            @(negedge clk);
        end
        checkOutput("b2b_end_bv", bvB, 0);
        checkOutput("b2b_end_din", dinB, 0);

        // Instance B: 0x80 LSB first puts the single one on the last bit
        @(posedge clk);
        #1 ifb.in_valid = 1'b1; ifb.in_chan = 3'd0; ifb.in_data = 8'h80;
        @(negedge clk);
        checkOutput("b80_rdy", ifb.in_ready, 1);
        @(posedge clk);
        #1 ifb.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b80_wait", bvB, 0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checkOutput("b80_bv", bvB, 1);
            checkOutput("b80_sel", selB, 0);
            checkOutput("b80_din", dinB, (i == 7));
            checkOutput("b80_last", lastB, (i == 7));
            @(negedge clk);
        end
        checkOutput("b80_end_bv", bvB, 0);
        checkOutput("b80_busy", busyB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux_serial_feeder.md
Name: demux_serial_feeder

Overview:
- Upstream stage of the 1-to-8 demultiplexer. It drives that block's din and sel ports.
- Accepts {channel, data word} transfers on a valid/ready handshake and buffers one word.
- Serialises the word bit-by-bit onto din while holding sel at the target channel. Each bit routes to the addressed output line.
- Inserts a programmable idle gap between words, with din=0 so every demux output is low during the gap.

Parameters:
- DATA_W, 8: payload bits per word (legal range 2..32).
- GAP_CYCLES, 1: idle cycles inserted after each word's last bit (legal range 0..15).
- MSB_FIRST, 1: 1 = shift MSB first; 0 = shift LSB first.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a word.
- in_ready  output  1  holding register empty. Transfer occurs when in_valid && in_ready at the rising edge.
- in_chan  input  3  target demux channel 0..7.
- in_data  input  DATA_W  payload.
- abort  input  1  synchronous flush; discards the held word and the word in flight.
- din  output  1  serial bit to the demux.
- sel  output  3  channel select to the demux.
- bit_valid  output  1  din carries a payload bit this cycle.
- last_bit  output  1  final bit of the current word (asserted only when bit_valid=1).
- busy  output  1  FSM is not IDLE, or the holding register is full.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - din=0, sel=3'b000, bit_valid=0, last_bit=0, busy=0.
  - Holding register empty; FSM=IDLE; bit counter=0; gap counter=0.
  - in_ready is forced 0 while rst_n=0. It becomes 1 in the first cycle after release.
- in_ready = !hold_full && rst_n. Combinational from registered state; it does not depend on in_valid.
- All of din, sel, bit_valid and last_bit are registered.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If hold_full: at the next edge, load the shifter from the holding register, set sel=held channel, drive the first bit on din, set bit_valid=1, set counter=DATA_W-1, clear hold_full, and go to SHIFT.
  - Otherwise: din=0 and bit_valid=0; sel keeps its last value.
- SHIFT:
  - Each edge shifts out the next bit, MSB or LSB per MSB_FIRST.
  - last_bit=1 on the cycle the counter reads 0.
  - After the last bit:
    - If GAP_CYCLES>0, go to GAP with gap counter=GAP_CYCLES-1, din=0, bit_valid=0.
    - If GAP_CYCLES=0 and hold_full, load the next word directly (back-to-back, no dead cycle).
    - Otherwise go to IDLE.
- GAP:
  - din=0, bit_valid=0, sel held.
  - When the gap counter reaches 0: load the next word if hold_full (same action as IDLE), else go to IDLE.
- Latency: a word accepted at edge E appears as its first bit after edge E+1 when the FSM is IDLE.
- Word duration: exactly DATA_W bit_valid cycles, then exactly GAP_CYCLES idle cycles.
- Buffering: one word may be accepted while another shifts. in_ready returns to 1 on the edge that moves the held word into the shifter.
- Acceptance and load cannot occur on the same edge, because in_ready=0 whenever hold_full=1.
- abort:
  - Takes effect at the next edge and has priority over load and shift.
  - Clears hold_full, sets FSM=IDLE, din=0, bit_valid=0, last_bit=0. sel is unchanged.
  - If in_valid&&in_ready&&abort occur on the same edge, the offered word is dropped.
- Reset asserted mid-word: outputs go to reset values immediately; there is no partial-word completion.
- in_chan and in_data are captured only on a transfer edge; changes at other times are ignored.

Test Plan:
- Reset release, MSB_FIRST=1, DATA_W=8, GAP=1.
  - Send chan=5, data=8'hA5.
  - Required: din=1,0,1,0,0,1,0,1 over 8 cycles, with sel=5 and bit_valid=1 throughout; last_bit only on the 8th bit.
  - Then 1 cycle with bit_valid=0 and din=0.
- Back-to-back words, GAP=0.
  - chan=2 data=8'hFF accepted, then chan=7 data=8'h01 accepted during the first word.
  - Required: 16 consecutive bit_valid cycles.
  - sel switches 2→7 exactly at bit 9.
  - in_ready deasserts for the second offer until the first load.
- MSB_FIRST=0, data=8'h80, chan=0.
  - Required: din=0 for bits 1-7 and din=1 on bit 8, with last_bit=1 on that bit.
- Assert abort at bit 4 of word chan=3 data=8'hF0, with a held word pending.
  - Required: next cycle bit_valid=0 and in_ready=1.
  - The held word is never emitted; busy=0.
- Assert rst_n=0 asynchronously mid-SHIFT.
  - Required: din, bit_valid and last_bit go to 0 without waiting for a clock edge; sel=0 and in_ready=0.
  - After release, a new word shifts normally.
- Hold in_valid=1 with in_ready=0 for 5 cycles while changing in_data.
  - Required: only the value present at the accepting edge is serialised.
